pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised, handshaked pipeline stage register. It is the generalised replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control vector and one data vector per entry.
- Uses a valid/ready handshake instead of a bare write-enable.
- An optional 2-entry skid buffer breaks the combinational ready path.
- A flush inserts a bubble: all valid bits clear and the control outputs are forced to a safe "no side effect" encoding.
- A saturating counter records back-pressure cycles for performance debug.

Parameters:
CTRL_W, 16, width of the control vector (RegWrite, MemWrite, ALUOp, ...).
DATA_W, 160, width of the data payload (instruction, operands, immediate, PC+4).
BUBBLE_CTRL, 0, value driven on Out_Ctrl whenever Out_Valid=0.
SKID, 1, 1 = 2-entry skid buffer (registered In_Ready); 0 = single entry (In_Ready combinational).
CNT_W, 16, width of the back-pressure counter.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
In_Valid  in  1  upstream entry present
In_Ready  out  1  stage can accept an entry this cycle
In_Ctrl  in  CTRL_W  upstream control vector
In_Data  in  DATA_W  upstream data payload
Out_Valid  out  1  entry presented downstream
Out_Ready  in  1  downstream accepts this cycle
Out_Ctrl  out  CTRL_W  control of the head entry; BUBBLE_CTRL when invalid
Out_Data  out  DATA_W  data of the head entry
Flush  in  1  synchronous bubble insertion, drops all held entries
Count_Clear  in  1  synchronous clear of Stall_Count
Occupancy  out  2  number of held entries (0..2)
Stall_Count  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Handshakes:
  - In-handshake (acc) = In_Valid & In_Ready.
  - Out-handshake (pop) = Out_Valid & Out_Ready.
  - All state updates occur on the rising Clock edge.
- Reset (async, any time, including mid-transfer):
  - Occupancy=0, Out_Valid=0, Out_Ctrl=BUBBLE_CTRL, Out_Data=0, Stall_Count=0, skid register cleared.
  - In_Ready=1 for the whole reset duration.
- Latency: an entry accepted at edge N is visible on Out_* after edge N (1 cycle), both with and without skid.
- SKID=1, states EMPTY / ONE / FULL; In_Ready = (state != FULL), registered:
  - EMPTY: acc -> ONE, main <= In.
  - ONE:
    - acc & pop -> ONE, main <= In.
    - acc & !pop -> FULL, skid <= In.
    - !acc & pop -> EMPTY.
    - otherwise hold.
  - FULL: pop -> ONE, main <= skid. No accept is possible in FULL.
  - Order is always preserved; the skid entry is never overtaken.
- SKID=0, states EMPTY / ONE:
  - In_Ready = !Out_Valid | Out_Ready (combinational).
  - acc -> main <= In, state ONE.
  - pop & !acc -> EMPTY.
- Flush (highest priority below Reset):
  - Next state is EMPTY regardless of acc/pop in the same cycle.
  - A pop in the flush cycle is still a valid delivery downstream.
  - An acc in the flush cycle is dropped.
  - Out_Data keeps its last value; Out_Ctrl goes to BUBBLE_CTRL because Out_Valid=0.
- Out_Ctrl = Out_Valid ? head_ctrl : BUBBLE_CTRL at all times.
- Data fields are not qualified by valid; consumers qualify with Out_Valid.
- Occupancy encoding: EMPTY=0, ONE=1, FULL=2.
- Stall_Count:
  - Increments each cycle with Out_Valid & !Out_Ready.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Count_Clear has priority over increment: clear -> 0 at that edge.
  - Flush does not affect the counter.
- No X propagation: the skid register is written only on an acc in state ONE without pop.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2).
  - Per-stage BUBBLE_CTRL constants (IDEX_BUBBLE, EXMEM_BUBBLE, ...).
  - Per-stage CTRL_W/DATA_W constants so the stage instances agree on field packing.
- One natural sub-module: pipe_sat_counter (CNT_W; inc, clr; saturating), reused by other performance counters.

Test Plan:
1. Reset mid-stream: SKID=1, state FULL holding A,B; assert Reset asynchronously between edges -> Out_Valid=0, Occupancy=0, Out_Ctrl=BUBBLE_CTRL, In_Ready=1 immediately, before the next edge.
2. Streaming: Out_Ready=1, push 0x11,0x22,0x33 on consecutive cycles -> Out_Data shows 0x11,0x22,0x33 on the following cycles, In_Ready stays 1, Occupancy=1, Stall_Count=0.
3. Back-pressure: SKID=1, Out_Ready=0, push A,B,C -> A,B accepted, Occupancy=2, In_Ready=0, C held upstream. Release Out_Ready -> outputs A,B,C in order. Stall_Count equals the number of cycles Out_Valid was high with Out_Ready low.
4. Flush collision: state ONE holding A, same cycle In_Valid=1 (D) and Out_Ready=1 and Flush=1 -> A counted as delivered, D dropped, next cycle Occupancy=0, Out_Ctrl=BUBBLE_CTRL (e.g. 16'h0000).
5. SKID=0 build: Out_Ready=0 with held entry -> In_Ready=0 in the same cycle; Out_Ready=1 -> In_Ready=1 combinationally, and simultaneous acc/pop keeps Occupancy=1.
6. Counter saturation: CNT_W=4, hold back-pressure 20 cycles -> Stall_Count=15. Count_Clear together with a stall cycle -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stage registers: state encoding,
// per-stage control/data widths and per-stage bubble encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Field packing shared by every stage instance of the core pipeline.
    localparam int unsigned IFID_CTRL_W  = 32'd16;
    localparam int unsigned IFID_DATA_W  = 32'd64;
    localparam int unsigned IDEX_CTRL_W  = 32'd16;
    localparam int unsigned IDEX_DATA_W  = 32'd160;
    localparam int unsigned EXMEM_CTRL_W = 32'd16;
    localparam int unsigned EXMEM_DATA_W = 32'd104;
    localparam int unsigned MEMWB_CTRL_W = 32'd16;
    localparam int unsigned MEMWB_DATA_W = 32'd72;

    // Bubble encodings: no register write, no memory access, no branch.
    localparam logic [15:0] IFID_BUBBLE  = 16'h0000;
    localparam logic [15:0] IDEX_BUBBLE  = 16'h0000;
    localparam logic [15:0] EXMEM_BUBBLE = 16'h0000;
    localparam logic [15:0] MEMWB_BUBBLE = 16'h0000;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occupancy(input pipe_state_e st);
        case (st)
            ST_EMPTY: state_occupancy = 2'd0;
            ST_ONE:   state_occupancy = 2'd1;
            ST_FULL:  state_occupancy = 2'd2;
            default:  state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer,
// flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W      = 16,
    parameter int unsigned        DATA_W      = 160,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
    parameter bit                 SKID        = 1'b1,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    input  logic              Flush,
    input  logic              Count_Clear,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  Stall_Count
);

    pipe_state_e       state_r;
    pipe_state_e       state_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic              skid_we_s;
    logic              acc_s;
    logic              pop_s;
    logic              ready_s;

    assign Out_Valid = (state_r != ST_EMPTY);
    assign acc_s     = In_Valid & ready_s;
    assign pop_s     = Out_Valid & Out_Ready;

    // With a skid buffer ready depends only on the state register; without
    // one it must look through to the downstream ready.
    generate
        if (SKID) begin : g_skid_ready
            assign ready_s = (state_r != ST_FULL);
        end else begin : g_flow_ready
            assign ready_s = ~Out_Valid | Out_Ready;
        end
    endgenerate

    assign In_Ready = ready_s;

    // Next-state and head-entry selection.
    always_comb begin
        state_s     = state_r;
        main_ctrl_s = main_ctrl_r;
        main_data_s = main_data_r;
        skid_we_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (acc_s) begin
                    state_s     = ST_ONE;
                    main_ctrl_s = In_Ctrl;
                    main_data_s = In_Data;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (acc_s && pop_s) begin
                    state_s     = ST_ONE;
                    main_ctrl_s = In_Ctrl;
                    main_data_s = In_Data;
                end else if (acc_s && SKID) begin
                    state_s   = ST_FULL;
                    skid_we_s = 1'b1;
                end else if (pop_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_s     = ST_ONE;
                    main_ctrl_s = skid_ctrl_r;
                    main_data_s = skid_data_r;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        // Flush drops held and incoming entries; the head data is left as is.
        if (Flush) begin
            state_s     = ST_EMPTY;
            main_ctrl_s = main_ctrl_r;
            main_data_s = main_data_r;
            skid_we_s   = 1'b0;
        end else begin
            skid_we_s = skid_we_s;
        end
    end

    // State and head-entry registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= BUBBLE_CTRL;
            main_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            main_ctrl_r <= main_ctrl_s;
            main_data_r <= main_data_s;
        end
    end

    // Skid register, written only when an entry arrives behind a stalled head.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (skid_we_s) begin
            skid_ctrl_r <= In_Ctrl;
            skid_data_r <= In_Data;
        end else begin
            skid_ctrl_r <= skid_ctrl_r;
            skid_data_r <= skid_data_r;
        end
    end

    // Control output is registered already masked to the bubble encoding.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_ctrl_r <= BUBBLE_CTRL;
        end else if (state_s != ST_EMPTY) begin
            out_ctrl_r <= main_ctrl_s;
        end else begin
            out_ctrl_r <= BUBBLE_CTRL;
        end
    end

    assign Out_Ctrl  = out_ctrl_r;
    assign Out_Data  = main_data_r;
    assign Occupancy = state_occupancy(state_r);

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (Clock),
        .rst   (Reset),
        .inc   (Out_Valid & ~Out_Ready),
        .clr   (Count_Clear),
        .count (Stall_Count)
    );

endmodule
